// File: rtl/dda_out_replay_source.sv
// Replays one frame of pre-computed DDA ray records from a synchronous ROM onto a
// valid/ready/last stream. Reads are credit-gated into a small skid FIFO so the
// stream runs at full rate and never loses a record under backpressure.
module dda_out_replay_source #(
  parameter int unsigned NUM_RAYS    = 320,
  parameter int unsigned DATA_WIDTH  = 38,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned ROM_LATENCY = 2
) (
  input  logic                  pixel_clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  output logic [ADDR_WIDTH-1:0] rom_addr_out,
  input  logic [DATA_WIDTH-1:0] rom_data_in,
  output logic                  m_tvalid_out,
  input  logic                  m_tready_in,
  output logic [DATA_WIDTH-1:0] m_tdata_out,
  output logic                  m_tlast_out,
  output logic                  busy_out,
  output logic                  overrun_out,
  output logic [7:0]            frames_sent_out
);

  localparam int unsigned DEPTH = ROM_LATENCY + 2;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TOT_W = $clog2(2 * DEPTH + 1);
  localparam int unsigned ENT_W = DATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_RAYS - 1);
  localparam bit FIRST_IS_LAST = (NUM_RAYS == 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  issue_q;
  logic                  issue_last_q;
  logic [ROM_LATENCY-1:0] pipe_vld_q;
  logic [ROM_LATENCY-1:0] pipe_last_q;
  logic [ENT_W-1:0]      fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  overrun_q;
  logic [7:0]            frames_q;

  logic [ENT_W-1:0]      head_c;
  logic                  valid_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  last_hs_c;
  logic [TOT_W-1:0]      credit_used_c;
  logic                  credit_ok_c;
  logic [ADDR_WIDTH-1:0] next_addr_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_c      = fifo_mem_q[rd_ptr_q];
  assign valid_c     = (count_q != '0);
  assign pop_c       = valid_c && m_tready_in;
  assign push_c      = pipe_vld_q[ROM_LATENCY-1];
  assign last_hs_c   = pop_c && head_c[DATA_WIDTH];
  assign next_addr_c = addr_q + ADDR_WIDTH'(1);

  // Credit: FIFO slots spoken for (stored + in flight), with this cycle's pop already freed
  always_comb begin
    credit_used_c = TOT_W'(count_q) + TOT_W'(issue_q);
    for (int i = 0; i < int'(ROM_LATENCY); i++) begin
      credit_used_c = credit_used_c + TOT_W'(pipe_vld_q[i]);
    end
    credit_used_c = credit_used_c - TOT_W'(pop_c);
    credit_ok_c   = (credit_used_c < TOT_W'(DEPTH));
  end

  // Frame FSM: address issue, overrun detection and frame counting
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_q      <= 1'b0;
      issue_last_q <= 1'b0;
      overrun_q    <= 1'b0;
      frames_q     <= '0;
    end else begin
      issue_q      <= 1'b0;
      issue_last_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start_in) begin
            addr_q       <= '0;
            issue_q      <= 1'b1;
            issue_last_q <= FIRST_IS_LAST;
            state_q      <= FIRST_IS_LAST ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (frame_start_in) overrun_q <= 1'b1;
          if (credit_ok_c) begin
            addr_q       <= next_addr_c;
            issue_q      <= 1'b1;
            issue_last_q <= (next_addr_c == LAST_ADDR);
            if (next_addr_c == LAST_ADDR) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_hs_c) begin
            frames_q <= frames_q + 8'd1;
            // A start landing on the final handshake chains straight into the next frame
            if (frame_start_in) begin
              addr_q       <= '0;
              issue_q      <= 1'b1;
              issue_last_q <= FIRST_IS_LAST;
              state_q      <= FIRST_IS_LAST ? DRAIN : STREAM;
            end else begin
              state_q <= IDLE;
            end
          end else if (frame_start_in) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // In-flight pipe mirroring the ROM read latency, carrying the last-record flag
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q[0]  <= issue_q;
      pipe_last_q[0] <= issue_last_q;
      for (int i = 1; i < int'(ROM_LATENCY); i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  // Skid FIFO pointers and occupancy
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Skid FIFO storage; contents are masked at the output while empty
  always_ff @(posedge pixel_clk_in) begin
    if (push_c) fifo_mem_q[wr_ptr_q] <= {pipe_last_q[ROM_LATENCY-1], rom_data_in};
  end

  assign rom_addr_out    = addr_q;
  assign m_tvalid_out    = valid_c;
  assign m_tdata_out     = valid_c ? head_c[DATA_WIDTH-1:0] : '0;
  assign m_tlast_out     = valid_c && head_c[DATA_WIDTH];
  assign busy_out        = (state_q != IDLE);
  assign overrun_out     = overrun_q;
  assign frames_sent_out = frames_q;

endmodule
